// File: rtl/dcm_input_filter.sv
// Two-flop sync + consecutive-sample glitch filter for motor pulse/fault/otw.
// Optional per-channel glitch counters: define DCM_INPUT_FILTER_GLITCH_CNT_EN.
module dcm_input_filter #(
    parameter int N_CHANNELS = 8,
    parameter int PULSE_LEN  = 4,
    parameter int FAULT_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CHANNELS-1:0]   raw_pulse,
    input  logic [N_CHANNELS-1:0]   raw_fault,
    input  logic [N_CHANNELS-1:0]   raw_otw,
    output logic [N_CHANNELS-1:0]   motor_pulse,
    output logic [N_CHANNELS-1:0]   motor_fault,
    output logic [N_CHANNELS-1:0]   motor_otw,
    output logic [N_CHANNELS-1:0]   pulse_rise,
    input  logic                    glitch_clear,
    output logic [8*N_CHANNELS-1:0] glitch_count
);
    localparam int NS = 3 * N_CHANNELS;
    localparam logic [7:0] PLM1 = 8'(PULSE_LEN - 1);
    localparam logic [7:0] FLM1 = 8'(FAULT_LEN - 1);

    logic [NS-1:0]         raw_all;
    logic [NS-1:0]         s1_q;
    logic [NS-1:0]         s2_q;
    logic [NS-1:0]         f_q;
    logic [NS-1:0]         f_d;
    logic [7:0]            c_q [NS];
    logic [7:0]            c_d [NS];
    logic [N_CHANNELS-1:0] rise_q;
    logic [N_CHANNELS-1:0] rise_d;

    // Signal order in the flat vectors: pulse, then fault, then otw.
    assign raw_all = {raw_otw, raw_fault, raw_pulse};

    always_comb begin
        f_d = f_q;
        for (int i = 0; i < NS; i++) begin
            c_d[i] = c_q[i];
            if (s2_q[i] == f_q[i]) begin
                c_d[i] = '0;
            end else if (c_q[i] == ((i < N_CHANNELS) ? PLM1 : FLM1)) begin
                f_d[i] = s2_q[i];
                c_d[i] = '0;
            end else begin
                c_d[i] = c_q[i] + 8'd1;
            end
        end
    end

    assign rise_d = f_d[N_CHANNELS-1:0] & ~f_q[N_CHANNELS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            f_q    <= '0;
            rise_q <= '0;
            for (int i = 0; i < NS; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            s1_q   <= raw_all;
            s2_q   <= s1_q;
            f_q    <= f_d;
            rise_q <= rise_d;
            for (int i = 0; i < NS; i++) begin
                c_q[i] <= c_d[i];
            end
        end
    end

    assign motor_pulse = f_q[N_CHANNELS-1:0];
    assign motor_fault = f_q[2*N_CHANNELS-1:N_CHANNELS];
    assign motor_otw   = f_q[3*N_CHANNELS-1:2*N_CHANNELS];
    assign pulse_rise  = rise_q;

`ifdef DCM_INPUT_FILTER_GLITCH_CNT_EN
    logic [N_CHANNELS-1:0] glitch_ev;
    logic [7:0]            g_q [N_CHANNELS];
    logic [7:0]            g_d [N_CHANNELS];

    // A glitch is a pulse disagreement abandoned before acceptance.
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            glitch_ev[i] = (s2_q[i] == f_q[i]) && (c_q[i] != 8'd0);
            g_d[i]       = g_q[i];
            if (glitch_clear) begin
                g_d[i] = '0;
            end else if (glitch_ev[i] && (g_q[i] != 8'hFF)) begin
                g_d[i] = g_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                g_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                g_q[i] <= g_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_cnt_out
        assign glitch_count[8*gi +: 8] = g_q[gi];
    end
`else
    logic unused_glitch_clear;

    assign unused_glitch_clear = glitch_clear;
    assign glitch_count        = '0;
`endif

endmodule
